// File: rtl/apb3_timer_pkg.sv
// Shared register map, control-bit layout and address-decode helper for apb3_timer.
package apb3_timer_pkg;

    localparam logic [4:0] CTRL_OFS     = 5'h00;
    localparam logic [4:0] PRESCALE_OFS = 5'h04;
    localparam logic [4:0] COMPARE_OFS  = 5'h08;
    localparam logic [4:0] COUNT_OFS    = 5'h0C;
    localparam logic [4:0] STATUS_OFS   = 5'h10;

    localparam int unsigned CTRL_EN_BIT          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT      = 2;
    localparam int unsigned STATUS_MATCH_BIT     = 0;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    function automatic logic ofs_valid(input logic [4:0] ofs);
        return (ofs[1:0] == 2'b00) && (ofs <= STATUS_OFS);
    endfunction

endpackage

// File: rtl/apb3_timer_prescaler.sv
// Prescaler: counts 0..i_presc while enabled and pulses o_tick on the terminal count.
module apb3_timer_prescaler
    import apb3_timer_pkg::*;
#(
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic [PRESC_WIDTH-1:0] i_presc,
    output logic                   o_tick
);

    logic [PRESC_WIDTH-1:0] psc_q;
    logic [PRESC_WIDTH-1:0] psc_d;

    assign o_tick = i_en && (psc_q == i_presc);

    always_comb begin
        psc_d = psc_q + 1'b1;
        if (i_clr || !i_en || o_tick) begin
            psc_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/apb3_timer.sv
// APB3 completer with a prescaled compare-match up-counter and level IRQ.
module apb3_timer
    import apb3_timer_pkg::*;
#(
    parameter int unsigned APB3_ADDR_WIDTH = 32,
    parameter int unsigned APB3_DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned PRESC_WIDTH     = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_psel,
    input  logic                       i_penable,
    input  logic                       i_pwrite,
    input  logic [APB3_ADDR_WIDTH-1:0] i_paddr,
    input  logic [APB3_DATA_WIDTH-1:0] i_pwdata,
    output logic [APB3_DATA_WIDTH-1:0] o_prdata,
    output logic                       o_pready,
    output logic                       o_pslverr,
    output logic                       o_irq
);

    logic [4:0] ofs;
    logic       addr_ok, setup, access, wr_en;
    logic       wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_status;
    logic       tick, hit;
    logic       unused_paddr;

    ctrl_t                      ctrl_q, ctrl_d;
    logic [PRESC_WIDTH-1:0]     presc_q, presc_d;
    logic [CNT_WIDTH-1:0]       cmp_q, cmp_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       match_q, match_d;
    logic [APB3_DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                       pslverr_q, pslverr_d;
    logic                       irq_q, irq_d;
    logic [APB3_DATA_WIDTH-1:0] rdata;

    assign ofs          = i_paddr[4:0];
    assign unused_paddr = ^i_paddr[APB3_ADDR_WIDTH-1:5];
    assign addr_ok      = ofs_valid(ofs);
    assign setup        = i_psel && !i_penable;
    assign access       = i_psel && i_penable;
    assign wr_en        = access && i_pwrite && addr_ok;
    assign wr_ctrl      = wr_en && (ofs == CTRL_OFS);
    assign wr_presc     = wr_en && (ofs == PRESCALE_OFS);
    assign wr_cmp       = wr_en && (ofs == COMPARE_OFS);
    assign wr_cnt       = wr_en && (ofs == COUNT_OFS);
    assign wr_status    = wr_en && (ofs == STATUS_OFS);

    apb3_timer_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (ctrl_q.en),
        .i_clr  (wr_ctrl || wr_presc),
        .i_presc(presc_q),
        .o_tick (tick)
    );

    always_comb begin
        rdata = '0;
        case (ofs)
            CTRL_OFS: begin
                rdata[CTRL_EN_BIT]          = ctrl_q.en;
                rdata[CTRL_AUTO_RELOAD_BIT] = ctrl_q.auto_reload;
                rdata[CTRL_IRQ_EN_BIT]      = ctrl_q.irq_en;
            end
            PRESCALE_OFS: rdata[PRESC_WIDTH-1:0] = presc_q;
            COMPARE_OFS:  rdata[CNT_WIDTH-1:0]   = cmp_q;
            COUNT_OFS:    rdata[CNT_WIDTH-1:0]   = cnt_q;
            STATUS_OFS:   rdata[STATUS_MATCH_BIT] = match_q;
            default:      rdata = '0;
        endcase
    end

    assign hit = tick && (cnt_q == cmp_q);

    // Tick effects are computed first; APB writes then override them, except
    // that a same-cycle match beats a W1C of MATCH.
    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        cmp_d     = cmp_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        prdata_d  = prdata_q;
        pslverr_d = setup && !addr_ok;

        if (setup) begin
            prdata_d = addr_ok ? rdata : '0;
        end

        if (tick) begin
            if (hit) begin
                if (ctrl_q.auto_reload) begin
                    cnt_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (wr_ctrl) begin
            ctrl_d.en          = i_pwdata[CTRL_EN_BIT];
            ctrl_d.auto_reload = i_pwdata[CTRL_AUTO_RELOAD_BIT];
            ctrl_d.irq_en      = i_pwdata[CTRL_IRQ_EN_BIT];
        end
        if (wr_presc) presc_d = i_pwdata[PRESC_WIDTH-1:0];
        if (wr_cmp)   cmp_d   = i_pwdata[CNT_WIDTH-1:0];
        if (wr_cnt)   cnt_d   = i_pwdata[CNT_WIDTH-1:0];

        if (wr_status && i_pwdata[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end

        irq_d = match_d && ctrl_d.irq_en;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_q    <= '0;
            presc_q   <= '0;
            cmp_q     <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            cmp_q     <= cmp_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign o_prdata  = prdata_q;
    assign o_pready  = 1'b1;
    assign o_pslverr = pslverr_q;
    assign o_irq     = irq_q;

endmodule

// File: tb/tb_apb3_timer.sv
// Self-checking bench for apb3_timer: cycle-level reference model plus directed and random APB traffic.
module tb_apb3_timer;

    logic        clk = 1'b0;
    logic        rst, psel, pen, pwr;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, irq;

    int unsigned nchk  = 0;
    int unsigned nfail = 0;
    bit          chk_en = 1'b0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb3_timer #(
        .APB3_ADDR_WIDTH(32),
        .APB3_DATA_WIDTH(32),
        .CNT_WIDTH      (32),
        .PRESC_WIDTH    (16)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_psel   (psel),
        .i_penable(pen),
        .i_pwrite (pwr),
        .i_paddr  (paddr),
        .i_pwdata (pwdata),
        .o_prdata (prdata),
        .o_pready (pready),
        .o_pslverr(pslverr),
        .o_irq    (irq)
    );

    // Reference model: architectural register state plus expected outputs.
    typedef struct {
        logic [2:0]  ctrl;
        logic [15:0] presc;
        logic [31:0] cmp;
        logic [31:0] cnt;
        logic        match;
        logic [15:0] psc;
        logic [31:0] prdata;
        logic        err;
        logic        irq;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mzero();
        mstate_t z;
        z.ctrl = '0; z.presc = '0; z.cmp = '0; z.cnt = '0; z.match = 1'b0;
        z.psc = '0; z.prdata = '0; z.err = 1'b0; z.irq = 1'b0;
        return z;
    endfunction

    function automatic logic [31:0] mread(mstate_t s, logic [4:0] ofs);
        case (ofs)
            5'h00:   return {29'd0, s.ctrl};
            5'h04:   return {16'd0, s.presc};
            5'h08:   return s.cmp;
            5'h0C:   return s.cnt;
            5'h10:   return {31'd0, s.match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic mstate_t step(mstate_t s, logic r, logic ps, logic pe, logic pw,
                                     logic [31:0] a, logic [31:0] wd);
        mstate_t    n;
        logic [4:0] ofs;
        logic       ok, tick, hit;
        if (r) return mzero();
        n    = s;
        ofs  = a[4:0];
        ok   = (ofs[1:0] == 2'b00) && (ofs <= 5'h10);
        n.err = ps && !pe && !ok;
        if (ps && !pe) n.prdata = ok ? mread(s, ofs) : 32'd0;
        tick = s.ctrl[0] && (s.psc == s.presc);
        hit  = tick && (s.cnt == s.cmp);
        n.psc = (!s.ctrl[0] || tick) ? 16'd0 : s.psc + 16'd1;
        if (tick) begin
            if (hit) begin
                n.match = 1'b1;
                if (s.ctrl[1]) n.cnt = 32'd0;
                else           n.ctrl[0] = 1'b0;
            end else begin
                n.cnt = s.cnt + 32'd1;
            end
        end
        if (ps && pe && pw && ok) begin
            case (ofs)
                5'h00: begin n.ctrl = wd[2:0]; n.psc = 16'd0; end
                5'h04: begin n.presc = wd[15:0]; n.psc = 16'd0; end
                5'h08: n.cmp = wd;
                5'h0C: n.cnt = wd;
                5'h10: if (wd[0] && !hit) n.match = 1'b0;
                default: ;
            endcase
        end
        n.irq = n.match && n.ctrl[2];
        return n;
    endfunction

    always @(posedge clk) m <= step(m, rst, psel, pen, pwr, paddr, pwdata);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_prdata",  prdata,  m.prdata);
            check("model_pslverr", {31'd0, pslverr}, {31'd0, m.err});
            check("model_irq",     {31'd0, irq},     {31'd0, m.irq});
            check("model_pready",  {31'd0, pready},  32'd1);
        end
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        pen = 1'b1;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; pen = 1'b0; pwr = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        psel = 1'b1; pen = 1'b0; pwr = 1'b0; paddr = a;
        @(negedge clk);
        pen = 1'b1;
        d   = prdata;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; pen = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, a;
        logic        e;
        int unsigned n, c0, sel;

        rst = 1'b1; psel = 1'b0; pen = 1'b0; pwr = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_prdata",  prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_irq",     {31'd0, irq}, 32'd0);
        check("rst_pready",  {31'd0, pready}, 32'd1);

        // Register read/write
        apb_read(32'h04, d, e);          check("presc_after_rst", d, 32'd0);
        apb_write(32'h08, 32'hDEADBEEF, e); check("wr_cmp_err", {31'd0, e}, 32'd0);
        apb_read(32'h08, d, e);          check("rd_cmp", d, 32'hDEADBEEF);
        check("rd_cmp_err", {31'd0, e}, 32'd0);

        // Error responses
        apb_read(32'h14, d, e);          check("err_rd_flag", {31'd0, e}, 32'd1);
        check("err_rd_data", d, 32'd0);
        apb_write(32'h02, 32'h0000_0007, e); check("err_wr_flag", {31'd0, e}, 32'd1);
        apb_read(32'h00, d, e);          check("err_ctrl_kept", d, 32'd0);
        apb_read(32'h08, d, e);          check("err_cmp_kept", d, 32'hDEADBEEF);

        // Periodic timer
        apb_write(32'h04, 32'd3, e);
        apb_write(32'h08, 32'd4, e);
        apb_write(32'h00, 32'h7, e);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("first_match_delay", n, 32'd20);
        c0 = cyc;
        apb_read(32'h0C, d, e);          check("count_after_match", d, 32'd0);
        apb_write(32'h10, 32'd1, e);     check("irq_after_w1c", {31'd0, irq}, 32'd0);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("match_period", cyc - c0, 32'd20);
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h10, 32'd1, e);

        // One-shot
        apb_write(32'h0C, 32'd0, e);
        apb_write(32'h04, 32'd0, e);
        apb_write(32'h08, 32'd2, e);
        apb_write(32'h00, 32'h1, e);
        repeat (6) @(negedge clk);
        apb_read(32'h00, d, e);          check("oneshot_ctrl", d, 32'd0);
        apb_read(32'h0C, d, e);          check("oneshot_count", d, 32'd2);
        apb_read(32'h10, d, e);          check("oneshot_match", d, 32'd1);
        check("oneshot_irq", {31'd0, irq}, 32'd0);

        // COUNT write on a tick cycle
        apb_write(32'h10, 32'd1, e);
        apb_write(32'h08, 32'hFFFF_0000, e);
        apb_write(32'h00, 32'h1, e);
        apb_write(32'h0C, 32'h10, e);
        apb_read(32'h0C, d, e);          check("cnt_write_wins", d, 32'h11);

        // W1C on a match cycle, then W1C with no match
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h0C, 32'd0, e);
        apb_write(32'h08, 32'd0, e);
        apb_write(32'h00, 32'h3, e);
        apb_write(32'h10, 32'd1, e);
        apb_read(32'h10, d, e);          check("set_beats_w1c", d, 32'd1);
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h10, 32'd1, e);
        apb_read(32'h10, d, e);          check("w1c_clears", d, 32'd0);

        // Wrap without match
        apb_write(32'h04, 32'd7, e);
        apb_write(32'h08, 32'd5, e);
        apb_write(32'h0C, 32'hFFFF_FFFF, e);
        apb_write(32'h00, 32'h1, e);
        repeat (8) @(negedge clk);
        apb_read(32'h0C, d, e);          check("wrap_count", d, 32'd0);
        apb_read(32'h10, d, e);          check("wrap_no_match", d, 32'd0);

        // Reset in the middle of an ACCESS write
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h04, 32'd0, e);
        apb_write(32'h08, 32'd0, e);
        apb_write(32'h0C, 32'd0, e);
        apb_write(32'h00, 32'h7, e);
        apb_read(32'h00, d, e);          check("pre_rst_ctrl", d, 32'h7);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 32'h08; pwdata = 32'h1234;
        @(negedge clk);
        pen = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; pen = 1'b0; pwr = 1'b0;
        check("post_rst_irq",    {31'd0, irq}, 32'd0);
        check("post_rst_prdata", prdata, 32'd0);
        apb_read(32'h08, d, e);          check("post_rst_cmp", d, 32'd0);
        apb_read(32'h00, d, e);          check("post_rst_ctrl", d, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 7);
            d = $urandom;
            case (sel)
                0: begin a = 32'h00; d = $urandom_range(0, 7); end
                1: begin a = 32'h04; d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3); end
                2: begin a = 32'h08; d = $urandom_range(0, 12); end
                3: begin a = 32'h0C; d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 10); end
                4: a = 32'h10;
                5: a = 32'h14 + 4 * $urandom_range(0, 2);
                6: a = (4 * $urandom_range(0, 4)) | $urandom_range(1, 3);
                default: begin a = ($urandom & 32'hFFFF_FFE0) | (4 * $urandom_range(0, 4)); d = $urandom_range(0, 7); end
            endcase
            if ($urandom_range(0, 1) == 1) apb_write(a, d, e);
            else                           apb_read(a, d, e);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
